// File: rtl/io_pwm_led_if.sv
// CPU store/load I/O bus as seen by a memory-mapped peripheral.
// The CPU side drives stores and read strobes; the peripheral returns read data.
interface io_pwm_led_if;
    logic [11:2] st_adr_io;
    logic [3:0]  st_we_io;
    logic [31:0] st_data_io;
    logic        ld_re_io;
    logic [11:2] ld_adr_io;
    logic [31:0] ld_data_io;

    modport master (
        output st_adr_io,
        output st_we_io,
        output st_data_io,
        output ld_re_io,
        output ld_adr_io,
        input  ld_data_io
    );

    modport slave (
        input  st_adr_io,
        input  st_we_io,
        input  st_data_io,
        input  ld_re_io,
        input  ld_adr_io,
        output ld_data_io
    );
endinterface

// File: rtl/io_pwm_led.sv
// Multi-channel LED/GPIO driver: off/on/pwm/blink per channel, shared prescaler,
// duty shadowed at PWM wrap, registered read-back on the CPU I/O bus.
module io_pwm_led #(
    parameter int unsigned CH   = 3,
    parameter int unsigned PW   = 8,
    parameter logic [9:0]  BASE = 10'h3F0
) (
    input  logic            clk,
    input  logic            rst,
    io_pwm_led_if.slave     bus,
    output logic [CH-1:0]   led_out
);

    logic                   en_q, en_d;
    logic [15:0]            pre_q, pre_d;
    logic [CH-1:0][PW-1:0]  duty_q, duty_d;
    logic [CH-1:0][1:0]     mode_q, mode_d;
    logic [CH-1:0][PW-1:0]  act_q, act_d;
    logic [15:0]            pre_cnt_q, pre_cnt_d;
    logic [PW-1:0]          pwm_cnt_q, pwm_cnt_d;
    logic                   blink_q, blink_d;
    logic [CH-1:0]          led_q, led_d;
    logic [31:0]            rdata_q, rdata_d;

    logic [9:0]             wr_off;
    logic [9:0]             rd_off;
    logic [31:0]            ctrl_val;
    logic [31:0]            wr_ctrl;
    logic [CH-1:0][31:0]    ch_val;
    logic [CH-1:0][31:0]    wr_ch;
    logic                   tick;
    logic                   wrap;

    function automatic logic [31:0] merge(
        input logic [31:0] cur,
        input logic [3:0]  we,
        input logic [31:0] wd
    );
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = we[k] ? wd[8*k +: 8] : cur[8*k +: 8];
        end
        return r;
    endfunction

    always_comb begin
        wr_off   = bus.st_adr_io - BASE;
        rd_off   = bus.ld_adr_io - BASE;
        ctrl_val = {pre_q, 15'd0, en_q};
        for (int i = 0; i < CH; i++) begin
            ch_val[i]          = '0;
            ch_val[i][25:24]   = mode_q[i];
            ch_val[i][PW-1:0]  = duty_q[i];
        end

        // Byte-merge against the programmed value so untouched fields survive.
        en_d    = en_q;
        pre_d   = pre_q;
        duty_d  = duty_q;
        mode_d  = mode_q;
        wr_ctrl = merge(ctrl_val, bus.st_we_io, bus.st_data_io);
        if (wr_off == 10'd0) begin
            en_d  = wr_ctrl[0];
            pre_d = wr_ctrl[31:16];
        end
        for (int i = 0; i < CH; i++) begin
            wr_ch[i] = merge(ch_val[i], bus.st_we_io, bus.st_data_io);
            if (wr_off == 10'(i + 1)) begin
                duty_d[i] = wr_ch[i][PW-1:0];
                mode_d[i] = wr_ch[i][25:24];
            end
        end

        rdata_d = rdata_q;
        if (bus.ld_re_io) begin
            rdata_d = '0;
            if (rd_off == 10'd0) begin
                rdata_d = ctrl_val;
            end
            for (int i = 0; i < CH; i++) begin
                if (rd_off == 10'(i + 1)) begin
                    rdata_d = ch_val[i];
                end
            end
        end
    end

    // A PRE lowered below pre_cnt lets the count run to all-ones and wrap.
    always_comb begin
        tick      = en_q && ((pre_cnt_q == pre_q) || (pre_cnt_q == 16'hFFFF));
        wrap      = tick && (pwm_cnt_q == '1);
        pre_cnt_d = '0;
        pwm_cnt_d = '0;
        if (en_q) begin
            pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
            pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        end
        blink_d = en_q ? (blink_q ^ wrap) : 1'b0;
        act_d   = (!en_q || wrap) ? duty_q : act_q;

        led_d = '0;
        for (int i = 0; i < CH; i++) begin
            if (en_q) begin
                unique case (mode_q[i])
                    2'd0: led_d[i] = 1'b0;
                    2'd1: led_d[i] = 1'b1;
                    2'd2: led_d[i] = pwm_cnt_q < act_q[i];
                    2'd3: led_d[i] = blink_q & (pwm_cnt_q < act_q[i]);
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            pre_q     <= '0;
            duty_q    <= '0;
            mode_q    <= '0;
            act_q     <= '0;
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
            blink_q   <= 1'b0;
            led_q     <= '0;
            rdata_q   <= '0;
        end else begin
            en_q      <= en_d;
            pre_q     <= pre_d;
            duty_q    <= duty_d;
            mode_q    <= mode_d;
            act_q     <= act_d;
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            blink_q   <= blink_d;
            led_q     <= led_d;
            rdata_q   <= rdata_d;
        end
    end

    assign led_out        = led_q;
    assign bus.ld_data_io = rdata_q;

endmodule
